// File: rtl/baud_pkg.sv
// Shared types and elaboration-time helpers for the baud tick generator.
package baud_pkg;

    localparam int DEF_DIV_W  = 16;
    localparam int DEF_FRAC_W = 4;

    typedef logic [DEF_DIV_W+DEF_FRAC_W-1:0] div_t;

    typedef enum logic [2:0] {
        B4800   = 3'd0,
        B9600   = 3'd1,
        B14400  = 3'd2,
        B19200  = 3'd3,
        B38400  = 3'd4,
        B57600  = 3'd5,
        B115200 = 3'd6,
        B128000 = 3'd7
    } baud_idx_e;

    localparam longint BAUD_TABLE [8] = '{
        4800, 9600, 14400, 19200, 38400, 57600, 115200, 128000
    };

    // Rounded fixed-point divisor: clk cycles per rx_tick, frac_w fraction bits.
    function automatic longint div_for(input longint baud, input longint clk,
                                       input longint ovs, input longint frac_w);
        longint den;
        den = baud * ovs;
        return ((clk << frac_w) + den / 2) / den;
    endfunction

endpackage

// File: rtl/frac_divider.sv
// Integer/fraction period counter; the accumulator spreads the fractional
// remainder so the long-run rx_tick rate is exact.
module frac_divider
    import baud_pkg::*;
#(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clr,
    input  logic [DIV_W+FRAC_W-1:0] div,
    output logic                    wrap,
    output logic                    rx_tick
);

    logic [DIV_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   sum;
    logic              carry;
    logic [DIV_W:0]    last;

    // The carry of the tick that ends this period stretches this period, so
    // the first period after enable/apply is exactly the integer part.
    assign sum   = {1'b0, acc} + {1'b0, div[FRAC_W-1:0]};
    assign carry = sum[FRAC_W];
    assign last  = {1'b0, div[DIV_W+FRAC_W-1:FRAC_W]} + (DIV_W+1)'(carry) - (DIV_W+1)'(1);
    assign wrap  = en && ({1'b0, cnt} == last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            acc     <= '0;
            rx_tick <= 1'b0;
        end else if (!en) begin
            cnt     <= '0;
            acc     <= '0;
            rx_tick <= 1'b0;
        end else begin
            rx_tick <= wrap;
            if (wrap) begin
                cnt <= '0;
                acc <= clr ? '0 : sum[FRAC_W-1:0];
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// UART baud tick generator: table or custom divisor, config applied at bit
// boundaries, rx oversampling tick, tx bit tick and legacy square clocks.
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int OVS         = 16,
    parameter int DIV_W       = 16,
    parameter int FRAC_W      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    cfg_mode,
    input  logic [2:0]              baud_sel,
    input  logic [DIV_W+FRAC_W-1:0] cust_div,
    input  logic                    cfg_load,
    output logic                    rx_tick,
    output logic                    tx_tick,
    output logic                    rx_clk,
    output logic                    tx_clk,
    output logic [DIV_W+FRAC_W-1:0] div_active,
    output logic                    cfg_err
);

    localparam int DW   = DIV_W + FRAC_W;
    localparam int PH_W = $clog2(OVS);
    localparam longint CF = longint'(CLK_FREQ_HZ);
    localparam longint OV = longint'(OVS);
    localparam longint FW = longint'(FRAC_W);

    localparam logic [DW-1:0] TBL [8] = '{
        DW'(div_for(BAUD_TABLE[0], CF, OV, FW)),
        DW'(div_for(BAUD_TABLE[1], CF, OV, FW)),
        DW'(div_for(BAUD_TABLE[2], CF, OV, FW)),
        DW'(div_for(BAUD_TABLE[3], CF, OV, FW)),
        DW'(div_for(BAUD_TABLE[4], CF, OV, FW)),
        DW'(div_for(BAUD_TABLE[5], CF, OV, FW)),
        DW'(div_for(BAUD_TABLE[6], CF, OV, FW)),
        DW'(div_for(BAUD_TABLE[7], CF, OV, FW))
    };
    localparam baud_idx_e RESET_SEL = B9600;

    logic [DW-1:0]   new_div;
    logic [DW-1:0]   pend_div;
    logic            pend;
    logic            load_ok;
    logic            wrap;
    logic            boundary;
    logic            apply;
    logic [PH_W-1:0] phase;

    assign new_div  = cfg_mode ? cust_div : TBL[baud_sel];
    assign load_ok  = cfg_load && (!cfg_mode || (cust_div[DW-1:FRAC_W] >= DIV_W'(2)));
    assign boundary = wrap && (phase == PH_W'(OVS - 1));
    // While disabled there is no bit in flight, so a load takes effect at once.
    assign apply    = pend && (!en || boundary);

    frac_divider #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clr     (apply),
        .div     (div_active),
        .wrap    (wrap),
        .rx_tick (rx_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_div   <= '0;
            pend       <= 1'b0;
            div_active <= TBL[RESET_SEL];
            cfg_err    <= 1'b0;
            phase      <= '0;
            tx_tick    <= 1'b0;
            rx_clk     <= 1'b0;
            tx_clk     <= 1'b0;
        end else begin
            cfg_err <= cfg_load && !load_ok;
            if (apply) begin
                div_active <= pend_div;
                pend       <= 1'b0;
            end
            // A load coinciding with apply is queued for the next boundary.
            if (load_ok) begin
                pend_div <= new_div;
                pend     <= 1'b1;
            end
            if (!en) begin
                phase   <= '0;
                tx_tick <= 1'b0;
                rx_clk  <= 1'b0;
                tx_clk  <= 1'b0;
            end else begin
                tx_tick <= boundary;
                if (wrap)
                    phase <= (phase == PH_W'(OVS - 1)) ? '0 : phase + PH_W'(1);
                rx_clk <= rx_clk ^ rx_tick;
                tx_clk <= tx_clk ^ tx_tick;
            end
        end
    end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen at 100 MHz with OVS=16 and a second OVS=4 copy.
module tb_baud_tick_gen;

    localparam int LIMIT = 2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        cfg_mode;
    logic [2:0]  baud_sel;
    logic [19:0] cust_div;
    logic        cfg_load;

    logic        rx_tick, tx_tick, rx_clk, tx_clk, cfg_err;
    logic [19:0] div_active;
    logic        rx_tick4, tx_tick4, rx_clk4, tx_clk4, cfg_err4;
    logic [19:0] div_active4;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    baud_tick_gen #(.CLK_FREQ_HZ(100_000_000), .OVS(16), .DIV_W(16), .FRAC_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_mode(cfg_mode), .baud_sel(baud_sel),
        .cust_div(cust_div), .cfg_load(cfg_load), .rx_tick(rx_tick), .tx_tick(tx_tick),
        .rx_clk(rx_clk), .tx_clk(tx_clk), .div_active(div_active), .cfg_err(cfg_err)
    );

    baud_tick_gen #(.CLK_FREQ_HZ(100_000_000), .OVS(4), .DIV_W(16), .FRAC_W(4)) dut_ovs4 (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_mode(cfg_mode), .baud_sel(baud_sel),
        .cust_div(cust_div), .cfg_load(cfg_load), .rx_tick(rx_tick4), .tx_tick(tx_tick4),
        .rx_clk(rx_clk4), .tx_clk(tx_clk4), .div_active(div_active4), .cfg_err(cfg_err4)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    endtask

    // Measures n rx_tick periods, starting from the current negedge.
    task automatic run_ticks(input bit use4, input int n, output int total, output int first_p,
                             output int min_p, output int max_p, output int tx_idx, output int ntx);
        int  p;
        logic rx, tx;
        total = 0; first_p = 0; min_p = 1 << 30; max_p = 0; tx_idx = 0; ntx = 0;
        for (int i = 1; i <= n; i++) begin
            p = 0;
            rx = 1'b0;
            while (!rx && p < LIMIT) begin
                @(negedge clk);
                p++;
                rx = use4 ? rx_tick4 : rx_tick;
            end
            if (!rx) begin
                chk("tick_timeout", rx, 1);
                return;
            end
            tx = use4 ? tx_tick4 : tx_tick;
            if (tx) begin
                ntx++;
                if (tx_idx == 0) tx_idx = i;
            end
            if (i == 1) first_p = p;
            total += p;
            if (p < min_p) min_p = p;
            if (p > max_p) max_p = p;
        end
    endtask

    task automatic load(input logic mode, input logic [2:0] sel, input logic [19:0] cd);
        cfg_mode = mode; baud_sel = sel; cust_div = cd; cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    initial begin
        int tot, fp, mn, mx, txi, ntx, p;
        logic prev;
        rst_n = 1'b0; en = 1'b0; cfg_mode = 1'b0; baud_sel = 3'd1; cust_div = '0; cfg_load = 1'b0;

        // Reset state: 9600 entry is {651,1} = 10417; OVS=4 copy is {2604,3} = 41667
        repeat (3) @(negedge clk);
        chk("rst_rx_tick", rx_tick, 0);
        chk("rst_tx_tick", tx_tick, 0);
        chk("rst_rx_clk", rx_clk, 0);
        chk("rst_tx_clk", tx_clk, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_div", div_active, 10417);
        chk("rst_div_ovs4", div_active4, 41667);

        // Default 9600 run
        rst_n = 1'b1; en = 1'b1;
        run_ticks(0, 16, tot, fp, mn, mx, txi, ntx);
        chk("9600_first", fp, 651);
        chk("9600_total16", tot, 10417);
        chk("9600_tx_idx", txi, 16);
        chk("9600_ntx", ntx, 1);

        // Custom {4,0} = 64 with en low: applies the cycle after the load
        en = 1'b0;
        @(negedge clk);
        chk("dis_rx_clk", rx_clk, 0);
        chk("dis_tx_clk", tx_clk, 0);
        load(1'b1, 3'd0, 20'd64);
        chk("c40_pending", div_active, 10417);
        @(negedge clk);
        chk("c40_div", div_active, 64);
        chk("c40_div_ovs4", div_active4, 64);
        en = 1'b1;
        run_ticks(1, 8, tot, fp, mn, mx, txi, ntx);
        chk("c40_first", fp, 4);
        chk("c40_min", mn, 4);
        chk("c40_max", mx, 4);
        chk("c40_tx_idx", txi, 4);
        chk("c40_ntx", ntx, 2);
        prev = rx_clk4; p = 0;
        while (!(rx_clk4 && !prev) && p < 100) begin prev = rx_clk4; @(negedge clk); p++; end
        prev = rx_clk4; p = 0;
        do begin prev = rx_clk4; @(negedge clk); p++; end while (!(rx_clk4 && !prev) && p < 100);
        chk("c40_rx_clk_period", p, 8);

        // Custom {4,8} = 72: periods 4,5,4,5..., 72 cycles over 16 ticks
        en = 1'b0;
        @(negedge clk);
        load(1'b1, 3'd0, 20'd72);
        @(negedge clk);
        chk("c48_div", div_active, 72);
        en = 1'b1;
        run_ticks(0, 16, tot, fp, mn, mx, txi, ntx);
        chk("c48_first", fp, 4);
        chk("c48_total16", tot, 72);
        chk("c48_min", mn, 4);
        chk("c48_max", mx, 5);
        chk("c48_tx_idx", txi, 16);

        // Back to 9600, then switch to 115200 ({54,4} = 868) mid-bit
        en = 1'b0;
        @(negedge clk);
        load(1'b0, 3'd1, 20'd0);
        @(negedge clk);
        chk("t9600_div", div_active, 10417);
        en = 1'b1;
        run_ticks(0, 3, tot, fp, mn, mx, txi, ntx);
        chk("t9600_3ticks", tot, 1953);
        load(1'b0, 3'd6, 20'd0);
        chk("sw_hold_div", div_active, 10417);
        run_ticks(0, 12, tot, fp, mn, mx, txi, ntx);
        chk("sw_hold_div12", div_active, 10417);
        chk("sw_no_tx_yet", ntx, 0);
        run_ticks(0, 1, tot, fp, mn, mx, txi, ntx);
        chk("sw_tx_at_boundary", txi, 1);
        chk("sw_div_applied", div_active, 868);
        run_ticks(0, 16, tot, fp, mn, mx, txi, ntx);
        chk("b115_first", fp, 54);
        chk("b115_min", mn, 54);
        chk("b115_total16", tot, 868);
        chk("b115_tx_idx", txi, 16);

        // Custom {1,15} = 31 is rejected
        load(1'b1, 3'd0, 20'd31);
        chk("rej_err_pulse", cfg_err, 1);
        @(negedge clk);
        chk("rej_err_clear", cfg_err, 0);
        chk("rej_div", div_active, 868);
        run_ticks(0, 1, tot, fp, mn, mx, txi, ntx);
        run_ticks(0, 16, tot, fp, mn, mx, txi, ntx);
        chk("rej_total16", tot, 868);
        chk("rej_min", mn, 54);
        chk("rej_max", mx, 55);
        chk("rej_ntx", ntx, 1);
        chk("rej_div_after", div_active, 868);

        // Reset mid-period with a pending 4800 load: load is discarded
        load(1'b0, 3'd0, 20'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_rx_tick", rx_tick, 0);
        chk("mrst_tx_tick", tx_tick, 0);
        chk("mrst_rx_clk", rx_clk, 0);
        chk("mrst_tx_clk", tx_clk, 0);
        chk("mrst_div", div_active, 10417);
        @(negedge clk);
        rst_n = 1'b1;
        run_ticks(0, 16, tot, fp, mn, mx, txi, ntx);
        chk("mrst_first", fp, 651);
        chk("mrst_total16", tot, 10417);
        chk("mrst_tx_idx", txi, 16);
        chk("mrst_div_kept", div_active, 10417);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
